// File: rtl/pattern_scanner_if.sv
// Frame handshake and LED-matrix drive signals of the pattern scanner.
// The scanner side uses the slave modport; the frame source / matrix model uses master.
interface pattern_scanner_if #(
  parameter int ROWS = 5,
  parameter int COLS = 24
);
  logic [ROWS*COLS-1:0] PatternSignal;
  logic                 FrameValid;
  logic                 FrameReady;
  logic                 SerData;
  logic                 SerClk;
  logic                 LatchOut;
  logic [ROWS-1:0]      RowEn;
  logic                 NextPattern;
  logic                 ScanBusy;

  modport slave (
    input  PatternSignal, FrameValid,
    output FrameReady, SerData, SerClk, LatchOut, RowEn, NextPattern, ScanBusy
  );

  modport master (
    output PatternSignal, FrameValid,
    input  FrameReady, SerData, SerClk, LatchOut, RowEn, NextPattern, ScanBusy
  );
endinterface

// File: rtl/pattern_scanner.sv
// Double-buffered row scanner for a shift-register LED matrix.
// Each row is shifted MSB first, latched, then lit; scans repeat forever once started.
module pattern_scanner #(
  parameter int ROWS              = 5,
  parameter int COLS              = 24,
  parameter int CLK_DIV           = 2,
  parameter int ON_CYCLES         = 64,
  parameter int SCANS_PER_PATTERN = 16
) (
  input  logic              Clock,
  input  logic              reset,
  pattern_scanner_if.slave  bus
);
  // state   | meaning
  // S_IDLE  | no frame seen since reset, matrix dark
  // S_SHIFT | shifting active row out, RowEn blanked
  // S_LATCH | one-cycle latch strobe
  // S_ON    | row lit for ON_CYCLES cycles
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH, S_ON} state_t;

  localparam int FW = ROWS * COLS;
  localparam int RW = $clog2(ROWS + 1);
  localparam int BW = $clog2(COLS + 1);
  localparam int DW = $clog2(2 * CLK_DIV + 1);
  localparam int OW = $clog2(ON_CYCLES + 1);
  localparam int SW = $clog2(SCANS_PER_PATTERN + 1);

  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(COLS - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV);
  localparam logic [OW-1:0] ON_LAST   = OW'(ON_CYCLES - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCANS_PER_PATTERN - 1);

  state_t          state_q, state_d;
  logic [FW-1:0]   active_q, active_d;
  logic [FW-1:0]   shadow_q, shadow_d;
  logic            pending_q, pending_d;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [DW-1:0]   div_q, div_d;
  logic [OW-1:0]   on_q, on_d;
  logic [SW-1:0]   scan_q, scan_d;
  logic            next_pattern_q, next_pattern_d;

  logic            accept;
  logic            swap;
  logic [COLS-1:0] row_bits;
  logic [COLS-1:0] row_shifted;

  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      active_q       <= '0;
      shadow_q       <= '0;
      pending_q      <= 1'b0;
      row_q          <= '0;
      bit_q          <= '0;
      div_q          <= '0;
      on_q           <= '0;
      scan_q         <= '0;
      next_pattern_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      active_q       <= active_d;
      shadow_q       <= shadow_d;
      pending_q      <= pending_d;
      row_q          <= row_d;
      bit_q          <= bit_d;
      div_q          <= div_d;
      on_q           <= on_d;
      scan_q         <= scan_d;
      next_pattern_q <= next_pattern_d;
    end
  end

  always_comb begin
    accept         = bus.FrameValid & ~pending_q;
    swap           = 1'b0;
    state_d        = state_q;
    active_d       = active_q;
    shadow_d       = shadow_q;
    pending_d      = pending_q;
    row_d          = row_q;
    bit_d          = bit_q;
    div_d          = div_q;
    on_d           = on_q;
    scan_d         = scan_q;
    next_pattern_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pending_q || accept) begin
          state_d = S_SHIFT;
          row_d   = '0;
          swap    = 1'b1;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = S_LATCH;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_LATCH: begin
        on_d    = '0;
        state_d = S_ON;
      end
      S_ON: begin
        if (on_q == ON_LAST) begin
          on_d    = '0;
          state_d = S_SHIFT;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            swap  = 1'b1;
            if (scan_q == SCAN_LAST) begin
              scan_d         = '0;
              next_pattern_d = 1'b1;
            end else begin
              scan_d = scan_q + SW'(1);
            end
          end else begin
            row_d = row_q + RW'(1);
          end
        end else begin
          on_d = on_q + OW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A frame accepted on the swap edge bypasses the shadow buffer entirely.
    if (swap && accept) begin
      active_d = bus.PatternSignal;
    end else if (swap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end else if (accept) begin
      shadow_d  = bus.PatternSignal;
      pending_d = 1'b1;
    end
  end

  always_comb begin
    row_bits = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == RW'(r)) row_bits = active_q[(ROWS-1-r)*COLS +: COLS];
    end
    row_shifted     = row_bits << bit_q;
    bus.FrameReady  = ~pending_q;
    bus.SerData     = (state_q == S_SHIFT) & row_shifted[COLS-1];
    bus.SerClk      = (state_q == S_SHIFT) && (div_q >= DIV_HALF);
    bus.LatchOut    = (state_q == S_LATCH);
    bus.RowEn       = (state_q == S_ON) ? (ROWS'(1) << row_q) : '0;
    bus.NextPattern = next_pattern_q;
    bus.ScanBusy    = (state_q != S_IDLE);
  end
endmodule

// File: tb/tb_pattern_scanner.sv
// Directed bench for pattern_scanner: default-parameter instance plus a fast
// instance with CLK_DIV=1, ON_CYCLES=1, SCANS_PER_PATTERN=1.
module tb_pattern_scanner;
  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  pattern_scanner_if bus_d ();
  pattern_scanner_if bus_f ();

  pattern_scanner u_dut (
    .Clock (clk),
    .reset (rst),
    .bus   (bus_d)
  );

  pattern_scanner #(
    .CLK_DIV           (1),
    .ON_CYCLES         (1),
    .SCANS_PER_PATTERN (1)
  ) u_fast (
    .Clock (clk),
    .reset (rst),
    .bus   (bus_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [119:0] FRAME_A = 120'h0000FF_000000_000000_000000_000000;
  localparam logic [119:0] FRAME_B = 120'hFF0000_00F000_0000AA_123456_ABCDEF;
  localparam logic [119:0] FRAME_C = 120'h13579B_2468AC_FEDCBA_0F0F0F_C3C3C3;
  localparam logic [119:0] FRAME_F = 120'hA5A5A5_000000_000000_000000_000000;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Observes one full default row (161 cycles) starting at its first SHIFT cycle.
  task automatic run_row(input logic [119:0] frame, input int r, input string tag);
    logic [23:0] got = '0;
    int rises = 0, latch_at = -1, latch_n = 0, on_n = 0, bad = 0;
    logic pclk = 1'b0, pdat = 1'b0;
    for (int c = 1; c <= 161; c++) begin
      if (bus_d.SerClk && !pclk) begin
        got = {got[22:0], bus_d.SerData};
        rises++;
      end
      if (bus_d.SerClk && pclk && (bus_d.SerData !== pdat)) bad++;
      if (bus_d.LatchOut) begin
        latch_at = c;
        latch_n++;
      end
      if (bus_d.RowEn !== 5'b0) begin
        if ((bus_d.RowEn === (5'b1 << r)) && (c > 97)) on_n++;
        else bad++;
        if (bus_d.SerClk || bus_d.LatchOut) bad++;
      end
      pclk = bus_d.SerClk;
      pdat = bus_d.SerData;
      step(1);
    end
    check({tag, ".bits"}, got, frame[(4-r)*24 +: 24]);
    check({tag, ".rises"}, rises, 24);
    check({tag, ".latch_at"}, latch_at, 97);
    check({tag, ".latch_n"}, latch_n, 1);
    check({tag, ".on_n"}, on_n, 64);
    check({tag, ".glitch"}, bad, 0);
  endtask

  int   t1, t2, wide, errs, latch_at, on_n;
  logic pnp;
  logic [23:0] got;

  initial begin
    rst = 1'b1;
    bus_d.FrameValid = 1'b0;
    bus_d.PatternSignal = '0;
    bus_f.FrameValid = 1'b0;
    bus_f.PatternSignal = '0;
    step(3);
    rst = 1'b0;

    check("rst.frame_ready", bus_d.FrameReady, 1);
    check("rst.outputs", {bus_d.SerData, bus_d.SerClk, bus_d.LatchOut, bus_d.RowEn,
                          bus_d.NextPattern, bus_d.ScanBusy}, 0);

    // First frame accepted straight into the active buffer.
    bus_d.PatternSignal = FRAME_A;
    bus_d.FrameValid = 1'b1;
    step(1);
    bus_d.FrameValid = 1'b0;
    check("start.busy", bus_d.ScanBusy, 1);
    check("start.ready", bus_d.FrameReady, 1);

    for (int r = 0; r < 5; r++) run_row(FRAME_A, r, $sformatf("scan1.r%0d", r));

    // Scan 2: frame B offered at row 2, C offered while B is pending.
    run_row(FRAME_A, 0, "scan2.r0");
    run_row(FRAME_A, 1, "scan2.r1");
    bus_d.PatternSignal = FRAME_B;
    bus_d.FrameValid = 1'b1;
    run_row(FRAME_A, 2, "scan2.r2");
    check("pend.ready_low", bus_d.FrameReady, 0);
    bus_d.PatternSignal = FRAME_C;
    run_row(FRAME_A, 3, "scan2.r3");
    run_row(FRAME_A, 4, "scan2.r4");
    check("swap.ready_high", bus_d.FrameReady, 1);

    run_row(FRAME_B, 0, "scan3.r0");
    check("c.accepted", bus_d.FrameReady, 0);
    bus_d.FrameValid = 1'b0;
    for (int r = 1; r < 5; r++) run_row(FRAME_B, r, $sformatf("scan3.r%0d", r));
    for (int r = 0; r < 5; r++) run_row(FRAME_C, r, $sformatf("scan4.r%0d", r));
    check("scan4.ready", bus_d.FrameReady, 1);

    // NextPattern period; first pulse is 16 scans after the first SHIFT entry.
    t1 = -1; t2 = -1; wide = 0; pnp = 1'b0;
    for (int i = 0; (i < 30000) && (t2 < 0); i++) begin
      if (bus_d.NextPattern) begin
        if (pnp) wide++;
        else if (t1 < 0) t1 = i;
        else t2 = i;
      end
      pnp = bus_d.NextPattern;
      if (t2 < 0) step(1);
    end
    check("np.first", t1, 9660);
    check("np.period", t2 - t1, 12880);
    check("np.width", wide, 0);

    // Reset in the middle of row 3's ON phase.
    step(590);
    check("pre_reset.row3", bus_d.RowEn, 5'b01000);
    rst = 1'b1;
    step(1);
    check("reset.rowen", bus_d.RowEn, 0);
    check("reset.serclk", bus_d.SerClk, 0);
    check("reset.busy", bus_d.ScanBusy, 0);
    check("reset.ready", bus_d.FrameReady, 1);
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus_d.ScanBusy || (bus_d.RowEn !== 5'b0) || bus_d.SerClk) errs++;
      step(1);
    end
    check("reset.stays_idle", errs, 0);

    // Fast instance: 50-cycle rows, NextPattern every scan.
    bus_f.PatternSignal = FRAME_F;
    bus_f.FrameValid = 1'b1;
    step(1);
    bus_f.FrameValid = 1'b0;
    got = '0; errs = 0; latch_at = -1; on_n = 0; pnp = 1'b0;
    for (int c = 1; c <= 50; c++) begin
      if (bus_f.SerClk && !pnp) got = {got[22:0], bus_f.SerData};
      pnp = bus_f.SerClk;
      if ((c <= 48) && (bus_f.SerClk !== ((c % 2) == 0))) errs++;
      if (bus_f.LatchOut) latch_at = c;
      if (bus_f.RowEn !== 5'b0) begin
        if ((c == 50) && (bus_f.RowEn === 5'b00001)) on_n++;
        else errs++;
      end
      step(1);
    end
    check("fast.bits", got, 24'hA5A5A5);
    check("fast.toggle", errs, 0);
    check("fast.latch_at", latch_at, 49);
    check("fast.on_n", on_n, 1);

    t1 = -1; t2 = -1; wide = 0; pnp = 1'b0;
    for (int i = 0; (i < 1000) && (t2 < 0); i++) begin
      if (bus_f.NextPattern) begin
        if (pnp) wide++;
        else if (t1 < 0) t1 = i;
        else t2 = i;
      end
      pnp = bus_f.NextPattern;
      if (t2 < 0) step(1);
    end
    check("fast.np.first", t1, 200);
    check("fast.np.period", t2 - t1, 250);
    check("fast.np.width", wide, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pattern_scanner.md
Name: pattern_scanner

Overview:
- Consumer of the 120-bit pattern frame: 5 rows × 24 columns, row 0 = bits [119:96], row 4 = bits [23:0].
- Double-buffers the frame and scans it row by row onto a shift-register LED matrix: serial data/clock, latch strobe, one-hot row enable.
- Issues a one-cycle NextPattern request after a programmable number of full scans, which drives the upstream pattern generator's advance clock.

Parameters:
- ROWS, 5, number of matrix rows (frame width = ROWS*COLS).
- COLS, 24, columns per row, shifted out MSB first.
- CLK_DIV, 2, Clock cycles per SerClk half-period (≥1).
- ON_CYCLES, 64, Clock cycles a row stays lit after latching (≥1).
- SCANS_PER_PATTERN, 16, full-frame scans between NextPattern pulses (≥1).

Ports:
- Clock  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- PatternSignal  in  120  frame data, sampled when FrameValid & FrameReady.
- FrameValid  in  1  upstream frame available.
- FrameReady  out  1  shadow buffer empty, can accept a frame.
- SerData  out  1  column bit to matrix shift chain.
- SerClk  out  1  shift clock; matrix samples SerData on rising edge.
- LatchOut  out  1  one-cycle strobe transferring shifted row to column drivers.
- RowEn  out  5  one-hot active row; all-zero while blanked.
- NextPattern  out  1  one-cycle pulse requesting the next pattern.
- ScanBusy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Reset (synchronous, overrides everything, including mid-row): state IDLE; active and shadow buffers = 0; pending = 0; row, bit, div, on and scan counters = 0.
  - Outputs after reset: SerData=0, SerClk=0, LatchOut=0, RowEn=0, NextPattern=0, ScanBusy=0.
  - FrameReady = !pending, so it is 1 on the first cycle after reset.
- Handshake: a frame is accepted on any edge with FrameValid & FrameReady. It goes to shadow and sets pending.
  - FrameValid without FrameReady has no effect. Upstream must hold the frame.
- States: IDLE, SHIFT, LATCH, ON.
- IDLE: if pending or an accept occurs this cycle, the next state is SHIFT with row=0.
  - On that transition, shadow (or PatternSignal directly if accepted this cycle) is copied to active, and pending is cleared.
- Swap rule: at every entry to SHIFT with row=0, if pending, copy shadow to active and clear pending. Otherwise re-scan the current active frame.
  - Accept and swap on the same edge: the newly accepted frame goes directly to active; pending stays 0.
- SHIFT: RowEn=0 (blanked).
  - Bits of active row `row` are driven MSB first.
  - Each bit: SerClk low for CLK_DIV cycles, then high for CLK_DIV cycles. SerData changes only while SerClk is low, at the start of each bit.
  - After COLS bits (COLS*2*CLK_DIV cycles), go to LATCH with SerClk=0.
- LATCH: exactly 1 cycle. LatchOut=1, SerClk=0. Then go to ON.
- ON: RowEn = 1<<row for ON_CYCLES cycles. Then:
  - If row<ROWS-1: row++ and go to SHIFT.
  - If row=ROWS-1: a scan is complete.
    - If scan=SCANS_PER_PATTERN-1: NextPattern=1 for the next single cycle and scan wraps to 0. Otherwise scan++.
    - row=0, and the next state is SHIFT (swap rule applies).
- The scan never returns to IDLE after the first frame. The matrix is refreshed continuously.
- Timing with defaults:
  - Row = 96 shift + 1 latch + 64 on = 161 cycles.
  - Scan = 805 cycles.
  - NextPattern period = 12880 cycles.
  - RowEn never overlaps LatchOut or SerClk activity.

Test Plan:
- Reset, then FrameValid=1 with PatternSignal=120'h0000FF_000000_000000_000000_000000 → accept on the first edge. Row 0 SerData = 16 zeros then 8 ones across 24 SerClk rising edges. LatchOut pulses at cycle 97 after SHIFT entry. RowEn=5'b00001 for 64 cycles. Rows 1–4 shift all zeros.
- Defaults, free-running after the first frame → NextPattern single-cycle pulses exactly 12880 cycles apart. RowEn steps 00001→00010→…→10000 every 161 cycles.
- New frame 120'hFF0000_… offered mid-scan (row 2) → FrameReady drops after accept. Rows 2–4 keep the old data. The new frame appears from the next row 0 and FrameReady returns to 1 on that swap.
- Second frame offered while pending=1 → FrameReady=0, no accept, shadow unchanged. Accepted on the edge after the swap.
- Assert reset during ON of row 3 → the next cycle has RowEn=0, SerClk=0, ScanBusy=0, FrameReady=1. The old frame is not redisplayed without a new handshake.
- CLK_DIV=1, ON_CYCLES=1, SCANS_PER_PATTERN=1 → row = 50 cycles. NextPattern pulses every 250 cycles. SerClk toggles every cycle during SHIFT.
